// File: rtl/display_counter_ctrl_if.sv
// Request/result bundle between the counter controller and its driver.
// master drives the count requests; slave is the controller itself.
interface display_counter_ctrl_if;
  logic       somar;
  logic       subtrair;
  logic       load;
  logic [9:0] load_value;
  logic [9:0] contagem;
  logic [11:0] valor;
  logic       busy;

  modport master (
    output somar, subtrair, load, load_value,
    input  contagem, valor, busy
  );

  modport slave (
    input  somar, subtrair, load, load_value,
    output contagem, valor, busy
  );
endinterface

// File: rtl/display_counter_ctrl.sv
// Up/down event counter with an iterative double-dabble converter feeding a 3-digit BCD display.
// Optional macro DISPLAY_COUNTER_WRAP_EN: wrap-around at the limits instead of saturating.
module display_counter_ctrl #(
  parameter int unsigned MAX_VALUE = 999,
  parameter int unsigned STEP      = 1
) (
  input logic              clk,
  input logic              reset,
  display_counter_ctrl_if.slave bus
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 11;
  localparam int unsigned BW = 12;
  localparam int unsigned SW = BW + CW;
  localparam int unsigned IW = 4;
  localparam logic [AW-1:0] MAX_A  = AW'(MAX_VALUE);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW-1:0] SPAN_A = AW'(MAX_VALUE + 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(CW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] valor_q, valor_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          dirty_q, dirty_clr, cnt_wr;
  logic          somar_q, subtrair_q;
  logic          rise_up, rise_dn;
  logic [AW-1:0] ext, sum;
  logic [SW-1:0] adj;

  // Add 3 to every BCD digit that would overflow past 9 on the next shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (b[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign rise_up = bus.somar & ~somar_q;
  assign rise_dn = bus.subtrair & ~subtrair_q;
  assign ext     = AW'(cnt_q);
  assign sum     = ext + STEP_A;
  assign adj     = {add3(sh_q[SW-1:CW]), sh_q[CW-1:0]};

  // Next count, in priority order: load, simultaneous rise, up, down.
  always_comb begin
    cnt_d  = cnt_q;
    cnt_wr = 1'b0;
    if (bus.load) begin
      cnt_wr = 1'b1;
      cnt_d  = (AW'(bus.load_value) > MAX_A) ? CW'(MAX_A) : bus.load_value;
    end else if (rise_up && rise_dn) begin
      cnt_wr = 1'b0;
    end else if (rise_up) begin
      cnt_wr = 1'b1;
      if (sum > MAX_A) begin
`ifdef DISPLAY_COUNTER_WRAP_EN
        cnt_d = CW'(sum - SPAN_A);
`else
        cnt_d = CW'(MAX_A);
`endif
      end else begin
        cnt_d = CW'(sum);
      end
    end else if (rise_dn) begin
      cnt_wr = 1'b1;
      if (ext < STEP_A) begin
`ifdef DISPLAY_COUNTER_WRAP_EN
        cnt_d = CW'(ext + SPAN_A - STEP_A);
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = CW'(ext - STEP_A);
      end
    end
  end

  // Conversion sequencer: snapshot, 10 shift-and-adjust steps, publish.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    iter_d    = iter_q;
    valor_d   = valor_q;
    dirty_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          sh_d      = {{BW{1'b0}}, cnt_q};
          iter_d    = '0;
          dirty_clr = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sh_d   = {adj[SW-2:0], 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        valor_d = sh_q[SW-1:CW];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valor_q    <= '0;
      sh_q       <= '0;
      iter_q     <= '0;
      dirty_q    <= 1'b0;
      somar_q    <= 1'b1;
      subtrair_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valor_q    <= valor_d;
      sh_q       <= sh_d;
      iter_q     <= iter_d;
      // A write on the same edge as the snapshot keeps dirty set for a rerun.
      dirty_q    <= cnt_wr | (dirty_q & ~dirty_clr);
      somar_q    <= bus.somar;
      subtrair_q <= bus.subtrair;
    end
  end

  assign bus.contagem = cnt_q;
  assign bus.valor    = valor_q;
  assign bus.busy     = dirty_q | (state_q != IDLE);

endmodule

// File: tb/tb_display_counter_ctrl.sv
// Directed bench for display_counter_ctrl: counting, limits, latency, restart and reset abort.
module tb_display_counter_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  display_counter_ctrl_if bus ();

  display_counter_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bcd_ok(input logic [11:0] v, input int lo, input int hi);
    int d;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v[11:8] > 4'd9) return 1'b0;
    d = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    return (d >= lo) && (d <= hi);
  endfunction

  task automatic pulse_somar();
    @(negedge clk) bus.somar = 1'b1;
    @(negedge clk) bus.somar = 1'b0;
  endtask

  task automatic do_load(input logic [9:0] v);
    @(negedge clk) begin bus.load = 1'b1; bus.load_value = v; end
    @(negedge clk) bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.somar = 1'b0; bus.subtrair = 1'b0; bus.load = 1'b0; bus.load_value = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.contagem !== 10'd0) begin fails++; $display("FAIL reset_contagem got=%0d exp=0", bus.contagem); end
    checks++;
    if (bus.valor !== 12'h000) begin fails++; $display("FAIL reset_valor got=%h exp=000", bus.valor); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    @(negedge clk) bus.somar = 1'b1;
    @(negedge clk) bus.somar = 1'b0;
    checks++;
    if (bus.contagem !== 10'd1) begin fails++; $display("FAIL up_first_cnt got=%0d exp=1", bus.contagem); end
    repeat (11) @(negedge clk);
    checks++;
    if (bus.valor !== 12'h000 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL latency_e11 valor=%h busy=%b exp valor=000 busy=1", bus.valor, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.valor !== 12'h001 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL latency_e12 valor=%h busy=%b exp valor=001 busy=0", bus.valor, bus.busy);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      pulse_somar();
      repeat (19) @(negedge clk);
    end
    checks++;
    if (bus.contagem !== 10'd3) begin fails++; $display("FAIL up_cnt got=%0d exp=3", bus.contagem); end
    checks++;
    if (bus.valor !== 12'h003) begin fails++; $display("FAIL up_valor got=%h exp=003", bus.valor); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL up_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_upper_limit();
    do_load(10'd1023);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.contagem !== 10'd999 || bus.valor !== 12'h999) begin
      fails++; $display("FAIL load_clamp cnt=%0d valor=%h exp 999/999", bus.contagem, bus.valor);
    end
    do_load(10'd998);
    repeat (20) @(negedge clk);
    pulse_somar();
    repeat (20) @(negedge clk);
    pulse_somar();
    repeat (20) @(negedge clk);
`ifdef DISPLAY_COUNTER_WRAP_EN
    checks++;
    if (bus.contagem !== 10'd0 || bus.valor !== 12'h000) begin
      fails++; $display("FAIL upper_wrap cnt=%0d valor=%h exp 0/000", bus.contagem, bus.valor);
    end
`else
    checks++;
    if (bus.contagem !== 10'd999 || bus.valor !== 12'h999) begin
      fails++; $display("FAIL upper_sat cnt=%0d valor=%h exp 999/999", bus.contagem, bus.valor);
    end
`endif
  endtask

  task automatic test_lower_limit();
    do_load(10'd0);
    repeat (20) @(negedge clk);
    @(negedge clk) bus.subtrair = 1'b1;
    @(negedge clk) bus.subtrair = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL lower_busy got=%b exp=1", bus.busy); end
    repeat (20) @(negedge clk);
`ifdef DISPLAY_COUNTER_WRAP_EN
    checks++;
    if (bus.contagem !== 10'd999 || bus.valor !== 12'h999) begin
      fails++; $display("FAIL lower_wrap cnt=%0d valor=%h exp 999/999", bus.contagem, bus.valor);
    end
`else
    checks++;
    if (bus.contagem !== 10'd0 || bus.valor !== 12'h000) begin
      fails++; $display("FAIL lower_sat cnt=%0d valor=%h exp 0/000", bus.contagem, bus.valor);
    end
`endif
  endtask

  task automatic test_simultaneous();
    do_load(10'd250);
    repeat (20) @(negedge clk);
    @(negedge clk) begin bus.somar = 1'b1; bus.subtrair = 1'b1; end
    @(negedge clk) begin bus.somar = 1'b0; bus.subtrair = 1'b0; end
    checks++;
    if (bus.contagem !== 10'd250) begin fails++; $display("FAIL both_cnt got=%0d exp=250", bus.contagem); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL both_busy got=%b exp=0", bus.busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valor !== 12'h250) begin fails++; $display("FAIL both_valor got=%h exp=250", bus.valor); end
  endtask

  task automatic test_back_to_back();
    bit done;
    do_load(10'd456);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) bus.somar = 1'b1;
      checks++;
      if (!bcd_ok(bus.valor, 456, 461)) begin fails++; $display("FAIL b2b_valor got=%h exp 456..461", bus.valor); end
      @(negedge clk) bus.somar = 1'b0;
      checks++;
      if (!bcd_ok(bus.valor, 456, 461)) begin fails++; $display("FAIL b2b_valor got=%h exp 456..461", bus.valor); end
    end
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      checks++;
      if (!bcd_ok(bus.valor, 456, 461)) begin fails++; $display("FAIL b2b_valor got=%h exp 456..461", bus.valor); end
      if (bus.busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin fails++; $display("FAIL b2b_timeout busy=%b exp=0", bus.busy); end
    checks++;
    if (bus.contagem !== 10'd461 || bus.valor !== 12'h461) begin
      fails++; $display("FAIL b2b_final cnt=%0d valor=%h exp 461/461", bus.contagem, bus.valor);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk) begin bus.load = 1'b1; bus.load_value = 10'd123; end
    @(negedge clk) bus.load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.somar = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.contagem !== 10'd0 || bus.valor !== 12'h000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL abort cnt=%0d valor=%h busy=%b exp 0/000/0", bus.contagem, bus.valor, bus.busy);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.contagem !== 10'd0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL held_somar cnt=%0d busy=%b exp 0/0", bus.contagem, bus.busy);
    end
    bus.somar = 1'b0;
    pulse_somar();
    checks++;
    if (bus.contagem !== 10'd1) begin fails++; $display("FAIL post_reset_up got=%0d exp=1", bus.contagem); end
    repeat (15) @(negedge clk);
    checks++;
    if (bus.valor !== 12'h001) begin fails++; $display("FAIL post_reset_valor got=%h exp=001", bus.valor); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_count_up();
    test_upper_limit();
    test_lower_limit();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
